// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: level-counter width and default flag thresholds.
package fifo_pkg;

   localparam int unsigned AE_THRESH_DEFAULT = 4;
   localparam int unsigned AF_MARGIN_DEFAULT = 4;

   // Level counter spans 0..2**addrbits inclusive, so it needs one extra bit.
   function automatic int unsigned level_bits(input int unsigned addrbits);
      return addrbits + 1;
   endfunction

endpackage

// File: rtl/simple_dual_ram.sv
// One-write/one-read port RAM with a registered read data output.
module simple_dual_ram #(
   parameter int unsigned ADDRBITS = 11,
   parameter int unsigned DATABITS = 8,
   parameter int unsigned DEPTH    = 2**ADDRBITS
) (
   input  logic                clk,
   input  logic                write_en,
   input  logic [ADDRBITS-1:0] write_addr,
   input  logic [DATABITS-1:0] write_data,
   input  logic                read_en,
   input  logic [ADDRBITS-1:0] read_addr,
   output logic [DATABITS-1:0] read_data
);

   logic [DATABITS-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (write_en) mem[write_addr] <= write_data;
      if (read_en)  read_data <= mem[read_addr];
   end

endmodule

// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO: RAM storage plus a head/skid prefetch stage,
// level counter, almost-full/almost-empty and sticky error flags.
module fifo_fwft
   import fifo_pkg::*;
#(
   parameter int unsigned ADDRBITS  = 11,
   parameter int unsigned DATABITS  = 8,
   parameter int unsigned AF_THRESH = 2**ADDRBITS - AF_MARGIN_DEFAULT,
   parameter int unsigned AE_THRESH = AE_THRESH_DEFAULT
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [DATABITS-1:0]               write_data,
   input  logic                              write_en,
   output logic                              full,
   output logic [DATABITS-1:0]               read_data,
   output logic                              read_valid,
   input  logic                              read_en,
   output logic                              empty,
   output logic [level_bits(ADDRBITS)-1:0]   level,
   output logic                              almost_full,
   output logic                              almost_empty,
   output logic                              overflow,
   output logic                              underflow
);

   localparam int unsigned DEPTH = 2**ADDRBITS;
   localparam int unsigned LW    = level_bits(ADDRBITS);
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
   localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

   logic [ADDRBITS-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0]       ram_count;
   logic [DATABITS-1:0] skid, ram_rdata;
   logic                skid_valid, inflight;

   logic                push_c, pop_c, issue_c;
   logic [2:0]          occ_c;
   logic [LW-1:0]       level_next_c;
   logic [DATABITS-1:0] head_next_c, skid_next_c;
   logic                head_valid_next_c, skid_valid_next_c;

   simple_dual_ram #(
      .ADDRBITS (ADDRBITS),
      .DATABITS (DATABITS),
      .DEPTH    (DEPTH)
   ) u_ram (
      .clk        (clk),
      .write_en   (push_c),
      .write_addr (wr_ptr),
      .write_data (write_data),
      .read_en    (issue_c),
      .read_addr  (rd_ptr),
      .read_data  (ram_rdata)
   );

   // Handshake, prefetch issue and head/skid next-state.
   always_comb begin
      pop_c             = read_en && read_valid;
      push_c            = write_en && (!full || pop_c);
      occ_c             = 3'(read_valid) + 3'(skid_valid) + 3'(inflight);
      issue_c           = (ram_count != '0) && (occ_c < (3'd2 + 3'(pop_c)));
      level_next_c      = level + LW'(push_c) - LW'(pop_c);
      head_next_c       = read_data;
      skid_next_c       = skid;
      head_valid_next_c = read_valid;
      skid_valid_next_c = skid_valid;
      if (pop_c) begin
         head_next_c       = skid;
         head_valid_next_c = skid_valid;
         skid_valid_next_c = 1'b0;
      end
      // Returning RAM word fills the head if the pop freed it, else the skid.
      if (inflight) begin
         if (!head_valid_next_c) begin
            head_next_c       = ram_rdata;
            head_valid_next_c = 1'b1;
         end else begin
            skid_next_c       = ram_rdata;
            skid_valid_next_c = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         ram_count    <= '0;
         read_data    <= '0;
         skid         <= '0;
         read_valid   <= 1'b0;
         skid_valid   <= 1'b0;
         inflight     <= 1'b0;
         empty        <= 1'b1;
         level        <= '0;
         full         <= 1'b0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         wr_ptr       <= wr_ptr + ADDRBITS'(push_c);
         rd_ptr       <= rd_ptr + ADDRBITS'(issue_c);
         ram_count    <= ram_count + LW'(push_c) - LW'(issue_c);
         read_data    <= head_next_c;
         skid         <= skid_next_c;
         read_valid   <= head_valid_next_c;
         skid_valid   <= skid_valid_next_c;
         inflight     <= issue_c;
         empty        <= !head_valid_next_c;
         level        <= level_next_c;
         full         <= (level_next_c == DEPTH_L);
         almost_full  <= (level_next_c >= AF_L);
         almost_empty <= (level_next_c <= AE_L);
         if (write_en && full && !pop_c) overflow  <= 1'b1;
         if (read_en && !read_valid)     underflow <= 1'b1;
      end
   end

endmodule
